hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central pipeline hazard controller for the five-stage core (IF, RR, EX, MEM, WB). It drives the lock and flush inputs of the IF_RR, RR_EX, EX_MEM and MEM_WB latches and the PC lock. It detects three conditions and resolves them by stalling, bubbling or squashing: load-use hazards, taken branches and jumps resolved in EX, and data-memory wait states. It also keeps a stall-cycle counter and a sticky memory-timeout error.

## Interface
- LOAD_STALL_CYCLES, default 1: bubbles inserted per load-use hazard (1..15).
- MEM_TIMEOUT, default 255: consecutive busy cycles tolerated before err_o is raised (1..65535).
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- rs1_rr_i, rs2_rr_i  in  5 each  source registers of the instruction in RR.
- use_rs1_i, use_rs2_i  in  1 each  RR instruction actually reads rs1 / rs2.
- rd_ex_i  in  5  destination of the instruction in EX, from the RR_EX outputs.
- memread_ex_i  in  1  EX instruction is a load.
- redirect_i  in  1  taken branch or jump resolved in EX this cycle.
- dmem_busy_i  in  1  data memory is not ready; the MEM stage must hold.
- pc_lock_o, if_rr_lock_o, rr_ex_lock_o, ex_mem_lock_o  out  1 each  hold the register.
- if_rr_flush_o, rr_ex_flush_o, mem_wb_flush_o  out  1 each  zero the latch, inserting a bubble.
- stall_cnt_o  out  32  total cycles with pc_lock_o high; wraps modulo 2^32.
- err_o  out  1  sticky memory timeout.

## Operation
- Hazard definition: load_use = memread_ex_i & (rd_ex_i != 0) & ((use_rs1_i & rs1_rr_i == rd_ex_i) | (use_rs2_i & rs2_rr_i == rd_ex_i)).
- FSM states: RUN, LOAD_STALL, MEM_WAIT. Outputs are Mealy: they are a function of the state and the current inputs.
- Priority within any state, highest first: dmem_busy_i, then redirect_i, then load_use.
- Busy, in any state:
  - Outputs: pc_lock, if_rr_lock, rr_ex_lock, ex_mem_lock and mem_wb_flush high; all other flushes low.
  - Next state is MEM_WAIT.
  - The remaining-stall counter rem (4 bit) is frozen.
  - The busy counter increments, saturating.
- MEM_WAIT with busy low:
  - Outputs are evaluated as for the state being returned to, in the same cycle.
  - The return state is LOAD_STALL if rem != 0, otherwise RUN.
  - The busy counter clears.
- RUN:
  - redirect_i: if_rr_flush and rr_ex_flush high; no locks, so the PC loads the target.
  - Else load_use: pc_lock, if_rr_lock and rr_ex_flush high.
    - rem is set to LOAD_STALL_CYCLES-1.
    - Next state is LOAD_STALL if rem != 0, else RUN.
  - Else all outputs low.
- LOAD_STALL:
  - Outputs: pc_lock, if_rr_lock and rr_ex_flush high.
  - rem decrements; the FSM returns to RUN when rem reaches 0.
  - redirect_i in this state (illegal, since EX holds a bubble) still wins: RUN, rem cleared, redirect outputs driven.
- A redirect and a load-use in the same cycle produce only the redirect response, because the RR instruction is wrong-path.
- err_o sets when the busy counter reaches MEM_TIMEOUT.
  - It stays set until reset.
  - It has no effect on the stall outputs.
- stall_cnt_o increments on every cycle in which pc_lock_o is high.

## Timing
- Reset values: all outputs 0, state RUN, rem 0, busy counter 0, stall_cnt_o 0, err_o 0.
- Zero-cycle response: locks and flushes are valid in the same cycle as the triggering input and are sampled by the latches at the next rising edge.
- A load-use hazard costs exactly LOAD_STALL_CYCLES cycles, plus any busy cycles that intervene.
- A redirect costs 2 squashed instructions and a 1-cycle response.
- A busy stretch of N cycles freezes the pipeline for exactly N cycles and inserts N bubbles into MEM_WB.
- Reset mid-stall or mid-wait returns the block to RUN asynchronously; no pending stall survives reset.

## Structure
- Shared package core_pkg holds:
  - the state enum hz_state_t (RUN, LOAD_STALL, MEM_WAIT);
  - the register-index width constant REG_AW = 5;
  - the zero-register constant.
- One sub-module, hazard_detect: the purely combinational load_use comparator, reusable by the forwarding unit.
- The FSM, counters and output decode live in hazard_ctrl.

## Test plan
- Load-use stall:
  - Stimulus: memread_ex_i=1, rd_ex_i=5, rs1_rr_i=5, use_rs1_i=1, LOAD_STALL_CYCLES=1.
  - Required: one cycle with pc_lock, if_rr_lock and rr_ex_flush high; stall_cnt_o=1.
- Zero-register and unused-source cases produce no stall:
  - rd_ex_i=0 with rs1_rr_i=0 → no stall.
  - rd_ex_i=5, rs2_rr_i=5, use_rs2_i=0 → no stall.
- Multi-cycle stall interrupted by busy:
  - Stimulus: LOAD_STALL_CYCLES=3, hazard; busy asserted for 2 cycles during the 2nd stall cycle.
  - Required: 3 load-stall cycles plus 2 frozen cycles; stall_cnt_o=5.
- Redirect with a simultaneous hazard:
  - Stimulus: redirect_i and load_use both high.
  - Required: if_rr_flush and rr_ex_flush high, pc_lock low, state stays RUN.
- Busy holding back a redirect:
  - Stimulus: dmem_busy_i held 3 cycles while redirect_i=1.
  - Required: 3 cycles of all locks plus mem_wb_flush with no if_rr/rr_ex flush; then 1 redirect cycle.
- Timeout and reset:
  - Stimulus: MEM_TIMEOUT=4, busy held 6 cycles.
  - Required: err_o rises after the 4th busy cycle and stays high after busy drops.
  - Then: rst_ni pulsed low mid-busy → all outputs 0 and err_o 0.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared definitions for the five-stage core pipeline control:
//               hazard-controller state encoding, register-index width and
//               the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Purely combinational load-use comparator. Flags when the
//               load currently in EX writes a register that the instruction
//               in RR actually reads. Writes to the zero register never
//               create a dependency.
// Ports       : rs1_i, rs2_i     - RR source register indices
//               use_rs1_i/rs2_i  - RR instruction reads rs1 / rs2
//               rd_i             - EX destination register index
//               memread_i        - EX instruction is a load
//               load_use_o       - dependency detected
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import core_pkg::*;
(
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              memread_i,
  output logic              load_use_o
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1  = use_rs1_i && (rs1_i == rd_i);
  assign w_hit_rs2  = use_rs2_i && (rs2_i == rd_i);
  assign load_use_o = memread_i && (rd_i != REG_ZERO) && (w_hit_rs1 || w_hit_rs2);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Central hazard controller for the IF/RR/EX/MEM/WB pipeline.
//               Resolves data-memory wait states (freeze + MEM_WB bubble),
//               redirects from EX (squash IF_RR and RR_EX) and load-use
//               hazards (hold PC and IF_RR, bubble RR_EX). Outputs are Mealy.
//               Also counts PC-stall cycles and flags a sticky memory timeout.
// Ports       : clk_i, rst_ni            - clock, async active-low reset
//               rs1_rr_i, rs2_rr_i,
//               use_rs1_i, use_rs2_i     - RR operand usage
//               rd_ex_i, memread_ex_i    - EX load destination
//               redirect_i               - taken branch/jump in EX
//               dmem_busy_i              - data memory not ready
//               *_lock_o / *_flush_o     - pipeline latch controls
//               stall_cnt_o              - cycles with pc_lock_o high
//               err_o                    - sticky memory timeout
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] rs1_rr_i,
  input  logic [REG_AW-1:0] rs2_rr_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  input  logic [REG_AW-1:0] rd_ex_i,
  input  logic              memread_ex_i,
  input  logic              redirect_i,
  input  logic              dmem_busy_i,
  output logic              pc_lock_o,
  output logic              if_rr_lock_o,
  output logic              rr_ex_lock_o,
  output logic              ex_mem_lock_o,
  output logic              if_rr_flush_o,
  output logic              rr_ex_flush_o,
  output logic              mem_wb_flush_o,
  output logic [31:0]       stall_cnt_o,
  output logic              err_o
);

  localparam logic [3:0]  c_rem_init = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] c_timeout  = 16'(MEM_TIMEOUT);

  hz_state_t   r_state;
  hz_state_t   w_state_nxt;
  hz_state_t   w_eff_state;
  logic [3:0]  r_rem;
  logic [3:0]  w_rem_nxt;
  logic [15:0] r_busy_cnt;
  logic [15:0] w_busy_inc;
  logic [31:0] r_stall_cnt;
  logic        r_err;
  logic        w_load_use;

  hazard_detect u_detect (
    .rs1_i      (rs1_rr_i),
    .rs2_i      (rs2_rr_i),
    .use_rs1_i  (use_rs1_i),
    .use_rs2_i  (use_rs2_i),
    .rd_i       (rd_ex_i),
    .memread_i  (memread_ex_i),
    .load_use_o (w_load_use)
  );

  // Leaving MEM_WAIT: behave in this very cycle as the state being resumed,
  // so a frozen load stall continues without losing a cycle.
  always_comb begin
    w_eff_state = r_state;
    if (r_state == MEM_WAIT) begin
      w_eff_state = (r_rem != 4'd0) ? LOAD_STALL : RUN;
    end
  end

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  assign w_busy_inc = (r_busy_cnt == 16'hFFFF) ? r_busy_cnt : r_busy_cnt + 16'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= RUN;
      r_rem       <= 4'd0;
      r_busy_cnt  <= 16'd0;
      r_stall_cnt <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (dmem_busy_i) begin
        r_busy_cnt <= w_busy_inc;
        // Raised on the edge that completes the MEM_TIMEOUT-th busy cycle.
        if (w_busy_inc >= c_timeout) begin
          r_err <= 1'b1;
        end
      end else begin
        r_busy_cnt <= 16'd0;
      end
      if (pc_lock_o) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = w_eff_state;
    w_rem_nxt   = r_rem;
    if (dmem_busy_i) begin
      // Remaining stall count is frozen across the wait.
      w_state_nxt = MEM_WAIT;
    end else begin
      case (w_eff_state)
        RUN: begin
          if (redirect_i) begin
            w_state_nxt = RUN;
          end else if (w_load_use) begin
            w_rem_nxt   = c_rem_init;
            w_state_nxt = (c_rem_init != 4'd0) ? LOAD_STALL : RUN;
          end else begin
            w_state_nxt = RUN;
          end
        end
        LOAD_STALL: begin
          if (redirect_i) begin
            w_state_nxt = RUN;
            w_rem_nxt   = 4'd0;
          end else begin
            w_rem_nxt   = r_rem - 4'd1;
            w_state_nxt = (r_rem == 4'd1) ? RUN : LOAD_STALL;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_rem_nxt   = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (Mealy). Forced low while reset is held so the latches see
  // no stale control even if inputs are active.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_lock_o      = 1'b0;
    if_rr_lock_o   = 1'b0;
    rr_ex_lock_o   = 1'b0;
    ex_mem_lock_o  = 1'b0;
    if_rr_flush_o  = 1'b0;
    rr_ex_flush_o  = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (rst_ni) begin
      if (dmem_busy_i) begin
        pc_lock_o      = 1'b1;
        if_rr_lock_o   = 1'b1;
        rr_ex_lock_o   = 1'b1;
        ex_mem_lock_o  = 1'b1;
        mem_wb_flush_o = 1'b1;
      end else if (redirect_i) begin
        // Wrong-path RR instruction: squash rather than stall, even in
        // LOAD_STALL.
        if_rr_flush_o = 1'b1;
        rr_ex_flush_o = 1'b1;
      end else if ((w_eff_state == LOAD_STALL) ||
                   ((w_eff_state == RUN) && w_load_use)) begin
        pc_lock_o     = 1'b1;
        if_rr_lock_o  = 1'b1;
        rr_ex_flush_o = 1'b1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances share the
//               stimulus: dut_a (LOAD_STALL_CYCLES=1, MEM_TIMEOUT=4) and
//               dut_b (LOAD_STALL_CYCLES=3, MEM_TIMEOUT=255). Expected output
//               vectors are queued when inputs are driven and compared on the
//               following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  // Output vector order: pc_lock, if_rr_lock, rr_ex_lock, ex_mem_lock,
  //                      if_rr_flush, rr_ex_flush, mem_wb_flush
  localparam logic [6:0] c_none  = 7'b0000000;
  localparam logic [6:0] c_stall = 7'b1100010;
  localparam logic [6:0] c_redir = 7'b0000110;
  localparam logic [6:0] c_busy  = 7'b1111001;

  logic       clk_i;
  logic       rst_ni;
  logic [4:0] rs1_rr_i, rs2_rr_i, rd_ex_i;
  logic       use_rs1_i, use_rs2_i, memread_ex_i, redirect_i, dmem_busy_i;

  logic        a_pc, a_ifl, a_rel, a_exl, a_iff, a_ref, a_mwf, a_err;
  logic        b_pc, b_ifl, b_rel, b_exl, b_iff, b_ref, b_mwf, b_err;
  logic [31:0] a_cnt, b_cnt;
  logic [6:0]  out_a, out_b;

  assign out_a = {a_pc, a_ifl, a_rel, a_exl, a_iff, a_ref, a_mwf};
  assign out_b = {b_pc, b_ifl, b_rel, b_exl, b_iff, b_ref, b_mwf};

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rs1_rr_i(rs1_rr_i), .rs2_rr_i(rs2_rr_i),
    .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
    .rd_ex_i(rd_ex_i), .memread_ex_i(memread_ex_i),
    .redirect_i(redirect_i), .dmem_busy_i(dmem_busy_i),
    .pc_lock_o(a_pc), .if_rr_lock_o(a_ifl), .rr_ex_lock_o(a_rel),
    .ex_mem_lock_o(a_exl), .if_rr_flush_o(a_iff), .rr_ex_flush_o(a_ref),
    .mem_wb_flush_o(a_mwf), .stall_cnt_o(a_cnt), .err_o(a_err)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(255)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rs1_rr_i(rs1_rr_i), .rs2_rr_i(rs2_rr_i),
    .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
    .rd_ex_i(rd_ex_i), .memread_ex_i(memread_ex_i),
    .redirect_i(redirect_i), .dmem_busy_i(dmem_busy_i),
    .pc_lock_o(b_pc), .if_rr_lock_o(b_ifl), .rr_ex_lock_o(b_rel),
    .ex_mem_lock_o(b_exl), .if_rr_flush_o(b_iff), .rr_ex_flush_o(b_ref),
    .mem_wb_flush_o(b_mwf), .stall_cnt_o(b_cnt), .err_o(b_err)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    string      tag;
    bit         sel_b;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic clr();
    rs1_rr_i = '0; rs2_rr_i = '0; rd_ex_i = '0;
    use_rs1_i = 1'b0; use_rs2_i = 1'b0; memread_ex_i = 1'b0;
    redirect_i = 1'b0; dmem_busy_i = 1'b0;
  endtask

  task automatic hazard_rs1();
    memread_ex_i = 1'b1; rd_ex_i = 5'd5; rs1_rr_i = 5'd5; use_rs1_i = 1'b1;
  endtask

  task automatic expect_out(input string tag, input bit sel_b, input logic [6:0] v);
    exp_t e;
    e.tag = tag; e.sel_b = sel_b; e.val = v;
    sb.push_back(e);
  endtask

  // Compare queued expectations mid-cycle, then step to just after the edge.
  task automatic cyc();
    exp_t       e;
    logic [6:0] obs;
    @(negedge clk_i);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = e.sel_b ? out_b : out_a;
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    clr();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    clr();
    rst_ni = 1'b0;
    // Reset with busy active: outputs must still be low.
    dmem_busy_i = 1'b1;
    expect_out("rst_out_a", 1'b0, c_none);
    expect_out("rst_out_b", 1'b1, c_none);
    cyc();
    chk("rst_cnt_a", a_cnt, 32'd0);
    chk("rst_err_a", {31'd0, a_err}, 32'd0);
    clr();
    rst_ni = 1'b1;

    // Load-use with one bubble.
    hazard_rs1();
    expect_out("lu1_a", 1'b0, c_stall);
    cyc();
    clr();
    expect_out("lu1_after_a", 1'b0, c_none);
    cyc();
    chk("lu1_cnt_a", a_cnt, 32'd1);

    // Zero register and unused source.
    do_reset();
    memread_ex_i = 1'b1; rd_ex_i = 5'd0; rs1_rr_i = 5'd0; use_rs1_i = 1'b1;
    expect_out("zero_reg_a", 1'b0, c_none);
    cyc();
    rd_ex_i = 5'd5; rs1_rr_i = 5'd0; rs2_rr_i = 5'd5; use_rs2_i = 1'b0;
    expect_out("unused_rs2_a", 1'b0, c_none);
    cyc();
    use_rs2_i = 1'b1;
    expect_out("used_rs2_a", 1'b0, c_stall);
    cyc();
    clr();
    expect_out("used_rs2_after_a", 1'b0, c_none);
    cyc();
    chk("src_cnt_a", a_cnt, 32'd1);

    // Three-cycle stall with a 2-cycle busy stretch in its 2nd cycle.
    do_reset();
    hazard_rs1();
    expect_out("ls3_c1_b", 1'b1, c_stall);
    cyc();
    clr();
    dmem_busy_i = 1'b1;
    expect_out("ls3_busy1_b", 1'b1, c_busy);
    cyc();
    expect_out("ls3_busy2_b", 1'b1, c_busy);
    cyc();
    dmem_busy_i = 1'b0;
    expect_out("ls3_c2_b", 1'b1, c_stall);
    cyc();
    expect_out("ls3_c3_b", 1'b1, c_stall);
    cyc();
    expect_out("ls3_done_b", 1'b1, c_none);
    cyc();
    chk("ls3_cnt_b", b_cnt, 32'd5);

    // Redirect together with a load-use hazard.
    do_reset();
    hazard_rs1();
    redirect_i = 1'b1;
    expect_out("redir_lu_a", 1'b0, c_redir);
    expect_out("redir_lu_b", 1'b1, c_redir);
    cyc();
    clr();
    expect_out("redir_run_a", 1'b0, c_none);
    expect_out("redir_run_b", 1'b1, c_none);
    cyc();
    chk("redir_cnt_b", b_cnt, 32'd0);

    // Redirect arriving during a load stall still wins.
    do_reset();
    hazard_rs1();
    expect_out("ls_redir_c1_b", 1'b1, c_stall);
    cyc();
    clr();
    redirect_i = 1'b1;
    expect_out("ls_redir_c2_b", 1'b1, c_redir);
    cyc();
    clr();
    expect_out("ls_redir_run_b", 1'b1, c_none);
    cyc();
    chk("ls_redir_cnt_b", b_cnt, 32'd1);

    // Busy holding back a redirect.
    do_reset();
    redirect_i = 1'b1;
    dmem_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("busy_redir_%0d_a", i), 1'b0, c_busy);
      cyc();
    end
    dmem_busy_i = 1'b0;
    expect_out("busy_redir_go_a", 1'b0, c_redir);
    cyc();
    clr();
    expect_out("busy_redir_run_a", 1'b0, c_none);
    cyc();
    chk("busy_redir_cnt_a", a_cnt, 32'd3);
    chk("busy3_no_err_a", {31'd0, a_err}, 32'd0);

    // Timeout: err rises after the 4th consecutive busy cycle.
    do_reset();
    dmem_busy_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      expect_out($sformatf("to_busy_%0d_a", i), 1'b0, c_busy);
      cyc();
      chk($sformatf("to_err_%0d_a", i), {31'd0, a_err}, (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("to_err_b", {31'd0, b_err}, 32'd0);
    dmem_busy_i = 1'b0;
    expect_out("to_idle_a", 1'b0, c_none);
    cyc();
    chk("to_sticky_a", {31'd0, a_err}, 32'd1);
    chk("to_cnt_a", a_cnt, 32'd6);

    // Reset asserted mid-busy.
    dmem_busy_i = 1'b1;
    expect_out("pre_rst_a", 1'b0, c_busy);
    cyc();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_out_a", {25'd0, out_a}, 32'd0);
    chk("midrst_out_b", {25'd0, out_b}, 32'd0);
    chk("midrst_err_a", {31'd0, a_err}, 32'd0);
    chk("midrst_cnt_a", a_cnt, 32'd0);
    dmem_busy_i = 1'b0;
    #1;
    rst_ni = 1'b1;
    expect_out("post_rst_a", 1'b0, c_none);
    expect_out("post_rst_b", 1'b1, c_none);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
